irq_priority_arbiter: RTL and testbench

//  Shares the core's single interrupt line (irq_req / irq_ret) between N peripheral sources.
//  - Latches edge-type requests.
//  - Masks every source with the CSR mie-derived mask.
//  - Picks one winner by fixed priority and presents irq_req_o plus cause to the core.
//  - Waits for the core's mret (irq_ret_i), then pulses the winner's acknowledge.

---
 rtl/irq_pkg.sv | 12 +
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_priority_arbiter.sv | 109 ++++++++++
 tb/tb_irq_priority_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt priority arbiter.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK
    } irq_arb_state_t;

    localparam logic [31:0] IRQ_CAUSE_BASE_DEF = 32'h8000_0010;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set index of vec_i wins.
module irq_prio_enc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    // Scan high to low so the lowest set bit is written last.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/irq_priority_arbiter.sv
// Shares the core interrupt line among N_SRC sources: fixed priority,
// edge/level capture, mret handshake and one-cycle acknowledge.
module irq_priority_arbiter
    import irq_pkg::*;
#(
    parameter int               N_SRC      = 8,
    parameter logic [N_SRC-1:0] EDGE_MASK  = '0,
    parameter logic [31:0]      CAUSE_BASE = IRQ_CAUSE_BASE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic [N_SRC-1:0] irq_mask_i,
    input  logic             irq_ret_i,
    output logic             irq_req_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_SRC-1:0] irq_ack_o,
    output logic             busy_o
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

    irq_arb_state_t   state_q, state_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] src_d_q;
    logic [N_SRC-1:0] ack_q, ack_d;
    logic [N_SRC-1:0] elig;
    logic [IDX_W-1:0] win_q, win_d;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_vld;
    logic             req_q, req_d;
    logic [31:0]      cause_q, cause_d;

    assign elig = ((irq_src_i & ~EDGE_MASK) | pend_q) & irq_mask_i;

    // ack_q is one-hot on the winner exactly during ACK; a fresh edge overrides the clear.
    assign pend_d = (pend_q & ~ack_q)
                  | (irq_src_i & ~src_d_q & EDGE_MASK);

    irq_prio_enc #(
        .N (N_SRC),
        .W (IDX_W)
    ) u_enc (
        .vec_i   (elig),
        .idx_o   (enc_idx),
        .valid_o (enc_vld)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        req_d   = 1'b0;
        cause_d = '0;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (enc_vld) begin
                    state_d = REQ;
                    win_d   = enc_idx;
                    req_d   = 1'b1;
                    cause_d = CAUSE_BASE
                            + {{(32 - IDX_W){1'b0}}, enc_idx};
                end
            end
            REQ: begin
                if (irq_ret_i) begin
                    state_d = ACK;
                    ack_d   = ONE << win_q;
                end else begin
                    req_d   = 1'b1;
                    cause_d = cause_q;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pend_q  <= '0;
            src_d_q <= '0;
            win_q   <= '0;
            req_q   <= 1'b0;
            cause_q <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            src_d_q <= irq_src_i;
            win_q   <= win_d;
            req_q   <= req_d;
            cause_q <= cause_d;
            ack_q   <= ack_d;
        end
    end

    assign irq_req_o   = req_q;
    assign irq_cause_o = cause_q;
    assign irq_ack_o   = ack_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Directed self-checking bench for irq_priority_arbiter.
module tb_irq_priority_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  src;
    logic [7:0]  mask;
    logic        ret;
    logic        req;
    logic [31:0] cause;
    logic [7:0]  ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    irq_priority_arbiter #(
        .N_SRC      (8),
        .EDGE_MASK  (8'h08),
        .CAUSE_BASE (32'h8000_0010)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .irq_src_i   (src),
        .irq_mask_i  (mask),
        .irq_ret_i   (ret),
        .irq_req_o   (req),
        .irq_cause_o (cause),
        .irq_ack_o   (ack),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag,
                             input logic e_req,
                             input logic [31:0] e_cause,
                             input logic [7:0] e_ack,
                             input logic e_busy);
        check({tag, ".req"}, {31'b0, req}, {31'b0, e_req});
        check({tag, ".cause"}, cause, e_cause);
        check({tag, ".ack"}, {24'b0, ack}, {24'b0, e_ack});
        check({tag, ".busy"}, {31'b0, busy}, {31'b0, e_busy});
    endtask

    initial begin
        rst_n = 1'b0;
        src   = '0;
        mask  = '0;
        ret   = 1'b0;
        tick();
        tick();
        check_out("reset", 1'b0, 32'h0, 8'h00, 1'b0);
        rst_n = 1'b1;
        tick();
        check_out("post_reset", 1'b0, 32'h0, 8'h00, 1'b0);

        // 1: level src2
        mask = 8'hFF;
        src  = 8'h04;
        tick();
        check_out("t1_grant", 1'b1, 32'h8000_0012, 8'h00, 1'b1);
        ret = 1'b1;
        tick();
        check_out("t1_ack", 1'b0, 32'h0, 8'h04, 1'b1);
        ret = 1'b0;
        tick();
        check_out("t1_idle", 1'b0, 32'h0, 8'h00, 1'b0);
        tick();
        check_out("t1_regrant", 1'b1, 32'h8000_0012, 8'h00, 1'b1);
        src = 8'h00;
        ret = 1'b1;
        tick();
        check_out("t1_ack2", 1'b0, 32'h0, 8'h04, 1'b1);
        ret = 1'b0;
        tick();
        check_out("t1_done", 1'b0, 32'h0, 8'h00, 1'b0);

        // 2: src1 and src5 together
        src = 8'h22;
        tick();
        check_out("t2_src1", 1'b1, 32'h8000_0011, 8'h00, 1'b1);
        ret = 1'b1;
        src = 8'h20;
        tick();
        check_out("t2_ack1", 1'b0, 32'h0, 8'h02, 1'b1);
        ret = 1'b0;
        tick();
        check_out("t2_gap", 1'b0, 32'h0, 8'h00, 1'b0);
        tick();
        check_out("t2_src5", 1'b1, 32'h8000_0015, 8'h00, 1'b1);
        ret = 1'b1;
        src = 8'h00;
        tick();
        check_out("t2_ack5", 1'b0, 32'h0, 8'h20, 1'b1);
        ret = 1'b0;
        tick();

        // 3: edge source 3
        src = 8'h08;
        tick();
        check_out("t3_lat1", 1'b0, 32'h0, 8'h00, 1'b0);
        src = 8'h00;
        tick();
        check_out("t3_grant", 1'b1, 32'h8000_0013, 8'h00, 1'b1);
        ret = 1'b1;
        tick();
        check_out("t3_ack", 1'b0, 32'h0, 8'h08, 1'b1);
        ret = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("t3_pend_clr", 1'b0, 32'h0, 8'h00, 1'b0);
        end
        src = 8'h08;
        tick();
        src = 8'h00;
        tick();
        check_out("t3_grant2", 1'b1, 32'h8000_0013, 8'h00, 1'b1);
        ret = 1'b1;
        tick();
        check_out("t3_ack2", 1'b0, 32'h0, 8'h08, 1'b1);
        ret = 1'b0;
        src = 8'h08;
        tick();
        check_out("t3_idle2", 1'b0, 32'h0, 8'h00, 1'b0);
        src = 8'h00;
        tick();
        check_out("t3_regrant", 1'b1, 32'h8000_0013, 8'h00, 1'b1);
        ret = 1'b1;
        tick();
        check_out("t3_ack3", 1'b0, 32'h0, 8'h08, 1'b1);
        ret = 1'b0;
        tick();
        tick();
        check_out("t3_quiet", 1'b0, 32'h0, 8'h00, 1'b0);

        // 4: masking
        mask = 8'h00;
        src  = 8'h01;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t4_masked.req", {31'b0, req}, 32'h0);
        end
        mask = 8'h01;
        tick();
        check_out("t4_grant", 1'b1, 32'h8000_0010, 8'h00, 1'b1);
        mask = 8'h00;
        tick();
        tick();
        check_out("t4_hold", 1'b1, 32'h8000_0010, 8'h00, 1'b1);
        ret = 1'b1;
        tick();
        check_out("t4_ack", 1'b0, 32'h0, 8'h01, 1'b1);
        ret  = 1'b0;
        src  = 8'h00;
        mask = 8'hFF;
        tick();

        // 5: async reset during REQ
        src = 8'h01;
        tick();
        check_out("t5_grant", 1'b1, 32'h8000_0010, 8'h00, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("t5_async", 1'b0, 32'h0, 8'h00, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check_out("t5_regrant", 1'b1, 32'h8000_0010, 8'h00, 1'b1);
        ret = 1'b1;
        src = 8'h00;
        tick();
        check_out("t5_ack", 1'b0, 32'h0, 8'h01, 1'b1);
        ret = 1'b0;
        tick();

        // 6: ret in IDLE
        ret = 1'b1;
        tick();
        check_out("t6_ret", 1'b0, 32'h0, 8'h00, 1'b0);
        ret = 1'b0;
        tick();
        check_out("t6_after", 1'b0, 32'h0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
